hash_word_serializer: RTL and testbench
=======================================

HASH_WORD_SERIALIZER -- requirements
Module: hash_word_serializer

Interface
REQ-001 Parameter HASH_W, default 256, SHALL set the width of the hash digest input.
REQ-002 Parameter WORD_W, default 32, SHALL set the output word width; HASH_W SHALL be an integer multiple of WORD_W (NWORDS = HASH_W/WORD_W).
REQ-003 Parameter MSW_FIRST, default 1, SHALL emit the most-significant word first when 1 and the least-significant word first when 0.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 hash_data  input  HASH_W  SHALL carry the digest from the hash core.
REQ-007 hash_valid  input  1  SHALL indicate hash_data is valid.
REQ-008 hash_rdy  output  1  SHALL indicate the block will accept a digest this cycle.
REQ-009 word_data  output  WORD_W  SHALL carry the current output word.
REQ-010 word_valid  output  1  SHALL indicate word_data is valid.
REQ-011 word_ready  input  1  SHALL indicate the downstream sink accepts word_data.
REQ-012 word_last  output  1  SHALL mark the final word of a digest.
REQ-013 busy  output  1  SHALL be high whenever a captured digest has not been fully emitted.

Function
REQ-014 A digest transfer SHALL occur on a rising edge where hash_valid and hash_rdy are both high; a word transfer where word_valid and word_ready are both high.
REQ-015 FSM states SHALL be IDLE and SEND; IDLE -> SEND on digest transfer; SEND -> IDLE on transfer of the word with word_last high; no other transitions.
REQ-016 hash_rdy SHALL be a registered function of state: high in IDLE, low in SEND; it SHALL NOT depend combinationally on hash_valid or word_ready.
REQ-017 On a digest transfer, hash_data SHALL be captured into an internal HASH_W register and the word index reset to 0.
REQ-018 word_valid SHALL be high in SEND and low in IDLE; the first word SHALL be valid the cycle after the digest transfer (latency 1).
REQ-019 word_data SHALL be word index i of the captured digest, where index 0 is bits [HASH_W-1 -: WORD_W] if MSW_FIRST=1, else bits [WORD_W-1:0].
REQ-020 The word index SHALL increment by 1 on each word transfer and SHALL NOT change while word_ready is low; word_data and word_last SHALL be stable while word_valid is high and word_ready low.
REQ-021 word_last SHALL be high exactly when word_valid is high and the index equals NWORDS-1.
REQ-022 busy SHALL equal (state == SEND).
REQ-023 Changes on hash_data/hash_valid while in SEND SHALL NOT affect the captured digest or outputs.
REQ-024 Minimum digest period SHALL be NWORDS+1 cycles with word_ready held high (one IDLE cycle between digests).
REQ-025 hash_valid high in the same cycle the last word transfers SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-026 While rst is high at a rising edge: state <= IDLE, index <= 0, captured digest <= 0.
REQ-027 After reset: hash_rdy=1, word_valid=0, word_last=0, busy=0, word_data=0.
REQ-028 Reset asserted mid-SEND SHALL abandon the digest; no remaining words SHALL be emitted.

Structure
REQ-029 A shared package (sha_pkg) SHALL hold HASH_W default (256), WORD_W default (32), and the state enumeration typedef.
REQ-030 The block SHALL be a single module with no sub-modules; the word index counter SHALL be $clog2(NWORDS) bits wide.

Verification
REQ-031 Reset then idle: rst 2 cycles -> hash_rdy=1, word_valid=0, busy=0 every cycle.
REQ-032 Single digest, word_ready=1, MSW_FIRST=1, hash_data=256'h00000000_11111111_..._77777777 -> words 0x00000000..0x77777777 on 8 consecutive cycles starting 1 cycle after transfer; word_last only on 0x77777777; hash_rdy=0 for those 8 cycles.
REQ-033 Backpressure: same digest, word_ready low on cycles 2-4 of SEND -> word_data holds 0x11111111 for those cycles; no word lost or duplicated; 8 transfers total.
REQ-034 Back-to-back: hash_valid held high with two digests (A, B) -> B accepted exactly 9 cycles after A; B's first word follows A's last word after one gap cycle.
REQ-035 MSW_FIRST=0 with the REQ-032 digest -> words 0x77777777 down to 0x00000000; word_last on 0x00000000.
REQ-036 Reset after 3rd word transfer -> next cycle word_valid=0, hash_rdy=1; a new digest then emits all 8 words from index 0.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared defaults and state encoding for the hash digest datapath blocks.
package sha_pkg;

   localparam int HASH_W_DEFAULT = 256;
   localparam int WORD_W_DEFAULT = 32;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/hash_word_serializer.sv
// Captures a full hash digest and streams it out as WORD_W words with
// valid/ready handshaking and a last-word marker.
module hash_word_serializer
   import sha_pkg::*;
#(
   parameter int HASH_W    = HASH_W_DEFAULT,
   parameter int WORD_W    = WORD_W_DEFAULT,
   parameter int MSW_FIRST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [HASH_W-1:0] hash_data,
   input  logic              hash_valid,
   output logic              hash_rdy,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              word_last,
   output logic              busy
);

   localparam int NWORDS = HASH_W / WORD_W;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic [HASH_W-1:0] digest;

   // hash_rdy, word_valid and busy are registered copies of the state so
   // that nothing on the handshake outputs depends combinationally on inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         digest     <= '0;
         hash_rdy   <= 1'b1;
         word_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hash_valid && hash_rdy) begin
                  state      <= SEND;
                  digest     <= hash_data;
                  idx        <= '0;
                  hash_rdy   <= 1'b0;
                  word_valid <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            SEND: begin
               if (word_valid && word_ready) begin
                  if (idx == LAST_IDX) begin
                     state      <= IDLE;
                     idx        <= '0;
                     hash_rdy   <= 1'b1;
                     word_valid <= 1'b0;
                     busy       <= 1'b0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               hash_rdy   <= 1'b1;
               word_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   // Word 0 is the top slice when MSW_FIRST, otherwise the bottom slice.
   always_comb begin
      word_data = digest[WORD_W-1:0];
      for (int i = 0; i < NWORDS; i++) begin
         if (idx == IDX_W'(i)) begin
            if (MSW_FIRST != 0)
               word_data = digest[HASH_W-1-i*WORD_W -: WORD_W];
            else
               word_data = digest[i*WORD_W +: WORD_W];
         end
      end
   end

   assign word_last = word_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_hash_word_serializer.sv
// Directed bench for hash_word_serializer: MSW-first and LSW-first instances
// share stimulus; expected words are hand-listed per digest.
module tb_hash_word_serializer;

   logic         clk;
   logic         rst;
   logic [255:0] hash_data;
   logic         hash_valid;
   logic         word_ready;

   logic         hash_rdy,   hash_rdy_l;
   logic [31:0]  word_data,  word_data_l;
   logic         word_valid, word_valid_l;
   logic         word_last,  word_last_l;
   logic         busy,       busy_l;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] DIG_A = {32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                                     32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
   localparam logic [255:0] DIG_B = {32'hB0000000, 32'hB0000001, 32'hB0000002, 32'hB0000003,
                                     32'hB0000004, 32'hB0000005, 32'hB0000006, 32'hB0000007};

   hash_word_serializer #(.HASH_W(256), .WORD_W(32), .MSW_FIRST(1)) dut (
      .clk(clk), .rst(rst), .hash_data(hash_data), .hash_valid(hash_valid),
      .hash_rdy(hash_rdy), .word_data(word_data), .word_valid(word_valid),
      .word_ready(word_ready), .word_last(word_last), .busy(busy)
   );

   hash_word_serializer #(.HASH_W(256), .WORD_W(32), .MSW_FIRST(0)) dut_lsw (
      .clk(clk), .rst(rst), .hash_data(hash_data), .hash_valid(hash_valid),
      .hash_rdy(hash_rdy_l), .word_data(word_data_l), .word_valid(word_valid_l),
      .word_ready(word_ready), .word_last(word_last_l), .busy(busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy"},   64'(hash_rdy),   64'd1);
      chk({tag, "_vld"},   64'(word_valid), 64'd0);
      chk({tag, "_busy"},  64'(busy),       64'd0);
      chk({tag, "_last"},  64'(word_last),  64'd0);
   endtask

   logic [31:0] exp_w;
   int n, acc_n;
   int acc_t [2];
   int xfer_t [16];

   initial begin
      rst = 1'b1; hash_valid = 1'b0; hash_data = '0; word_ready = 1'b1;

      // Reset held for two cycles, then idle.
      for (int c = 0; c < 2; c++) begin
         tick();
         chk_idle("reset");
         chk("reset_data", 64'(word_data), 64'd0);
         chk("reset_vld_l", 64'(word_valid_l), 64'd0);
      end
      rst = 1'b0;
      tick();
      chk_idle("idle");

      // Single digest, full-rate sink; both word orders checked together.
      hash_data = DIG_A; hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0; hash_data = ~DIG_A;
      for (int k = 0; k < 8; k++) begin
         exp_w = 32'h11111111 * 32'(k);
         chk("single_vld",  64'(word_valid), 64'd1);
         chk("single_rdy",  64'(hash_rdy),   64'd0);
         chk("single_busy", 64'(busy),       64'd1);
         chk("single_data", 64'(word_data),  64'(exp_w));
         chk("single_last", 64'(word_last),  64'(k == 7));
         exp_w = 32'h11111111 * 32'(7 - k);
         chk("lsw_data", 64'(word_data_l), 64'(exp_w));
         chk("lsw_last", 64'(word_last_l), 64'(k == 7));
         tick();
      end
      chk_idle("single_end");
      chk("lsw_end_vld", 64'(word_valid_l), 64'd0);

      // Backpressure on SEND cycles 2-4.
      hash_data = DIG_A; hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      n = 0;
      for (int c = 1; c <= 20 && n < 8; c++) begin
         word_ready = !(c >= 2 && c <= 4);
         if (c >= 2 && c <= 4)
            chk("bp_hold", 64'(word_data), 64'h11111111);
         if (word_valid) begin
            exp_w = 32'h11111111 * 32'(n);
            chk("bp_data", 64'(word_data), 64'(exp_w));
            chk("bp_last", 64'(word_last), 64'(n == 7));
            if (word_ready) n++;
         end
         tick();
      end
      word_ready = 1'b1;
      chk("bp_count", 64'(n), 64'd8);
      chk_idle("bp_end");

      // Back-to-back digests with hash_valid held high.
      hash_data = DIG_A; hash_valid = 1'b1;
      acc_n = 0; n = 0;
      for (int cyc = 0; cyc < 40 && n < 16; cyc++) begin
         if (hash_valid && hash_rdy && acc_n < 2) begin
            acc_t[acc_n] = cyc;
            acc_n++;
         end
         if (word_valid && word_ready) begin
            exp_w = (n < 8) ? 32'h11111111 * 32'(n) : 32'hB0000000 + 32'(n - 8);
            chk("b2b_data", 64'(word_data), 64'(exp_w));
            xfer_t[n] = cyc;
            n++;
         end
         tick();
         if (acc_n == 1) hash_data = DIG_B;
         if (acc_n == 2) hash_valid = 1'b0;
      end
      hash_valid = 1'b0;
      chk("b2b_accepts", 64'(acc_n), 64'd2);
      chk("b2b_xfers", 64'(n), 64'd16);
      if (acc_n == 2 && n == 16) begin
         chk("b2b_gap", 64'(acc_t[1] - acc_t[0]), 64'd9);
         chk("b2b_a_last_t", 64'(xfer_t[7] - acc_t[0]), 64'd8);
         chk("b2b_b_first_t", 64'(xfer_t[8] - acc_t[0]), 64'd10);
      end

      // Reset after the third word transfer abandons the digest.
      tick();
      hash_data = DIG_A; hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      chk("mid_pre_data", 64'(word_data), 64'h33333333);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_idle("mid_rst");
      chk("mid_rst_data", 64'(word_data), 64'd0);
      tick();
      chk("mid_quiet_vld", 64'(word_valid), 64'd0);
      hash_data = DIG_B; hash_valid = 1'b1;
      tick();
      hash_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("restart_vld",  64'(word_valid), 64'd1);
         chk("restart_data", 64'(word_data),  64'(32'hB0000000 + 32'(k)));
         chk("restart_last", 64'(word_last),  64'(k == 7));
         tick();
      end
      chk_idle("restart_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
